// File: rtl/perceptron_train_queue_if.sv
// Prediction-in, resolution-in and weight write-back channels of the perceptron training queue.
// The master drives predictions and resolutions; the slave is the training queue itself.
interface perceptron_train_queue_if #(
  parameter int NUM_WEIGHTS = 16,
  parameter int WEIGHT_W    = 3,
  parameter int SUM_W       = 9,
  parameter int IDX_W       = 8
);
  logic                            pred_valid;
  logic                            pred_ready;
  logic [SUM_W-1:0]                pred_sum;
  logic                            pred_dir;
  logic [NUM_WEIGHTS-1:0]          pred_hist;
  logic [NUM_WEIGHTS*WEIGHT_W-1:0] pred_weights;
  logic [IDX_W-1:0]                pred_index;

  logic                            res_valid;
  logic                            res_ready;
  logic                            res_taken;

  logic                            upd_valid;
  logic                            upd_ready;
  logic [IDX_W-1:0]                upd_index;
  logic [NUM_WEIGHTS*WEIGHT_W-1:0] upd_weights;

  modport master (
    output pred_valid, pred_sum, pred_dir, pred_hist, pred_weights, pred_index,
    output res_valid, res_taken, upd_ready,
    input  pred_ready, res_ready, upd_valid, upd_index, upd_weights
  );

  modport slave (
    input  pred_valid, pred_sum, pred_dir, pred_hist, pred_weights, pred_index,
    input  res_valid, res_taken, upd_ready,
    output pred_ready, res_ready, upd_valid, upd_index, upd_weights
  );
endinterface

// File: rtl/perceptron_train_queue.sv
// In-order queue of in-flight perceptron predictions; each resolution pops the oldest entry,
// applies the perceptron training rule and issues a saturated weight write-back.
module perceptron_train_queue #(
  parameter int NUM_WEIGHTS = 16,
  parameter int WEIGHT_W    = 3,
  parameter int SUM_W       = 9,
  parameter int THETA       = 14,
  parameter int IDX_W       = 8,
  parameter int DEPTH       = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  perceptron_train_queue_if.slave    bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int WV_W  = NUM_WEIGHTS * WEIGHT_W;

  localparam logic signed [WEIGHT_W:0] WMAX = {2'b00, {(WEIGHT_W-1){1'b1}}};
  localparam logic signed [WEIGHT_W:0] WMIN = {2'b11, {(WEIGHT_W-1){1'b0}}};
  localparam logic signed [WEIGHT_W:0] ONE  = {{WEIGHT_W{1'b0}}, 1'b1};

  typedef struct packed {
    logic [SUM_W-1:0]       sum;
    logic                   dir;
    logic [NUM_WEIGHTS-1:0] hist;
    logic [WV_W-1:0]        weights;
    logic [IDX_W-1:0]       index;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_DECIDE, S_WRITE} state_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  entry_t           lat_q, lat_d;
  logic             taken_q, taken_d;
  logic [IDX_W-1:0] upd_index_q, upd_index_d;
  logic [WV_W-1:0]  upd_weights_q, upd_weights_d;
  logic             push, pop, train;
  logic [SUM_W:0]   sum_ext, sum_abs;
  logic [WV_W-1:0]  new_weights;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign bus.pred_ready = (cnt_q != OCC_W'(DEPTH));
  assign bus.res_ready  = (cnt_q != '0) && (state_q == S_IDLE) && !flush_i;
  assign push           = bus.pred_valid && bus.pred_ready && !flush_i;
  assign pop            = bus.res_valid && bus.res_ready;
  assign bus.upd_valid  = (state_q == S_WRITE);
  assign bus.upd_index  = upd_index_q;
  assign bus.upd_weights = upd_weights_q;
  assign occupancy_o    = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{sum: bus.pred_sum, dir: bus.pred_dir, hist: bus.pred_hist,
                                   weights: bus.pred_weights, index: bus.pred_index};
  end

  // Magnitude needs one extra bit so the most-negative sum stays positive.
  assign sum_ext = {lat_q.sum[SUM_W-1], lat_q.sum};
  assign sum_abs = sum_ext[SUM_W] ? (~sum_ext + 1'b1) : sum_ext;
  assign train   = (lat_q.dir != taken_q) || (sum_abs <= (SUM_W+1)'(THETA));

  for (genvar gi = 0; gi < NUM_WEIGHTS; gi++) begin : g_w
    logic signed [WEIGHT_W:0] ext, nxt;
    assign ext = {lat_q.weights[gi*WEIGHT_W+WEIGHT_W-1], lat_q.weights[gi*WEIGHT_W +: WEIGHT_W]};
    assign nxt = (lat_q.hist[gi] == taken_q) ? ext + ONE : ext - ONE;
    assign new_weights[gi*WEIGHT_W +: WEIGHT_W] = (nxt > WMAX) ? WMAX[WEIGHT_W-1:0] :
                                                  (nxt < WMIN) ? WMIN[WEIGHT_W-1:0] :
                                                                 nxt[WEIGHT_W-1:0];
  end

  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    taken_d       = taken_q;
    upd_index_d   = upd_index_q;
    upd_weights_d = upd_weights_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          lat_d   = mem_q[rd_ptr_q];
          taken_d = bus.res_taken;
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (train) begin
          upd_index_d   = lat_q.index;
          upd_weights_d = new_weights;
          state_d       = S_WRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: if (bus.upd_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      state_q       <= S_IDLE;
      lat_q         <= '0;
      taken_q       <= 1'b0;
      upd_index_q   <= '0;
      upd_weights_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      lat_q         <= lat_d;
      taken_q       <= taken_d;
      upd_index_q   <= upd_index_d;
      upd_weights_q <= upd_weights_d;
    end
  end
endmodule
